// File: rtl/mig_ui_pkg.sv
// Shared definitions for the MIG UI arbiter and the requester address generators.
package mig_ui_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    ARB      = 2'd1,
    GRANT    = 2'd2
  } arb_state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mig_ui_arbiter_if.sv
// MIG7 UI command/write/read-return bundle. The arbiter is the master, the MIG the slave.
interface mig_ui_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);

  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

endinterface

// File: rtl/mig_tag_fifo.sv
// Tag FIFO: remembers which requester issued each outstanding read, in issue order.
// A pop and a push in the same cycle are both honoured even when full.
module mig_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Tag storage.
  // NOTE: the storage array has no reset; occupancy lives in count, so stale entries are never read.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mig_ui_arbiter.sv
// Round-robin, quantum-limited arbiter sharing the MIG UI among streaming requesters,
// with read-return routing through a tag FIFO.
module mig_ui_arbiter
  import mig_ui_pkg::*;
#(
  parameter int                NUM_REQ      = 3,
  parameter logic [NUM_REQ-1:0] REQ_IS_WRITE = 3'b001,
  parameter int                ADDR_W       = 27,
  parameter int                DATA_W       = 128,
  parameter int                QUANTUM      = 8,
  parameter int                TAG_DEPTH    = 32
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            init_calib_complete,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_W-1:0]               rd_data_out,
  output logic [NUM_REQ-1:0]              rd_valid_out,
  output logic [NUM_REQ-1:0]              grant_out,
  output logic                            tag_err_out,
  mig_ui_arbiter_if.master                mig
);

  localparam int TAG_W = idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(QUANTUM + 1);

  arb_state_t         state;
  logic [TAG_W-1:0]   gidx;
  logic [TAG_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [CNT_W-1:0]   cnt;

  logic               tag_full;
  logic               tag_empty;
  logic [TAG_W-1:0]   tag_head;

  logic [NUM_REQ-1:0] elig;
  logic [TAG_W:0]     pick;
  logic               in_grant;
  logic               g_valid;
  logic               g_write;
  logic               accept;
  logic               grant_exit;

  // First eligible requester at or after ptr, wrapping; returns {found, index}.
  function automatic logic [TAG_W:0] rr_pick(input logic [NUM_REQ-1:0] elig_in,
                                             input logic [TAG_W-1:0]   ptr);
    logic [TAG_W:0] res;
    int             k;
    res = '0;
    // Walk from farthest to nearest so the nearest eligible index wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (elig_in[k]) res = {1'b1, k[TAG_W-1:0]};
    end
    return res;
  endfunction

  // Eligibility, the search result and the accept/exit conditions of the current grant.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    elig       = req_valid & (REQ_IS_WRITE | {NUM_REQ{~tag_full}});
    pick       = rr_pick(elig, rr_ptr);
    in_grant   = (state == GRANT);
    g_valid    = req_valid[gidx];
    g_write    = REQ_IS_WRITE[gidx];
    accept     = 1'b0;
    grant_exit = 1'b0;
    if (in_grant) begin
      accept     = g_valid & mig.app_rdy & (g_write ? mig.app_wdf_rdy : ~tag_full);
      grant_exit = (accept & (cnt == CNT_W'(QUANTUM - 1))) | ~g_valid | (~g_write & tag_full);
    end
  end

  // Command side is combinational from the registered grant: zero-cycle acceptance.
  assign mig.app_en       = accept;
  assign mig.app_cmd      = (in_grant & ~g_write) ? CMD_READ : CMD_WRITE;
  assign mig.app_addr     = in_grant ? req_addr[gidx] : '0;
  assign mig.app_wdf_data = (in_grant & g_write) ? req_wdata[gidx] : '0;
  assign mig.app_wdf_wren = accept & g_write;
  assign mig.app_wdf_end  = accept & g_write;
  assign req_ready        = accept ? grant : '0;
  assign grant_out        = grant;

  // Arbitration FSM: calibration hold-off, round-robin pick, quantum-limited grant.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= WAIT_CAL;
      rr_ptr <= '0;
      gidx   <= '0;
      grant  <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees this cycle's register values.
      case (state)
        WAIT_CAL: begin
          if (init_calib_complete) state <= ARB;
        end
        ARB: begin
          if (pick[TAG_W]) begin
            state <= GRANT;
            gidx  <= pick[TAG_W-1:0];
            grant <= NUM_REQ'(1) << pick[TAG_W-1:0];
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (accept) cnt <= cnt + 1'b1;
          if (grant_exit) begin
            state  <= ARB;
            grant  <= '0;
            rr_ptr <= (gidx == TAG_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          end
        end
        default: state <= WAIT_CAL;
      endcase
    end
  end

  mig_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (accept & ~g_write),
    .push_tag (gidx),
    .pop      (mig.app_rd_data_valid),
    .full     (tag_full),
    .empty    (tag_empty),
    .head     (tag_head)
  );

  // Read return: register each beat and steer it to the requester at the tag head.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_data_out  <= '0;
      rd_valid_out <= '0;
      tag_err_out  <= 1'b0;
    end else begin
      rd_valid_out <= '0;
      if (mig.app_rd_data_valid) begin
        rd_data_out <= mig.app_rd_data;
        if (tag_empty) tag_err_out  <= 1'b1;
        else           rd_valid_out <= NUM_REQ'(1) << tag_head;
      end
    end
  end

endmodule

// File: tb/tb_mig_ui_arbiter.sv
// Self-checking bench for mig_ui_arbiter: directed phases with randomized addresses and data,
// a MIG responder and a queue-based model of outstanding reads.
module tb_mig_ui_arbiter;
  import mig_ui_pkg::*;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;
  localparam int RD_LAT = 3;

  logic                        clk;
  logic                        rst_n;
  logic                        calib;
  logic [2:0]                  req_valid;
  logic [2:0][ADDR_W-1:0]      req_addr;
  logic [2:0][DATA_W-1:0]      req_wdata;
  logic [2:0]                  req_ready;
  logic [DATA_W-1:0]           rd_data_out;
  logic [2:0]                  rd_valid_out;
  logic [2:0]                  grant_out;
  logic                        tag_err_out;
  logic [2:0]                  wr_map;

  mig_ui_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mig_bus ();

  mig_ui_arbiter #(
    .NUM_REQ(3), .REQ_IS_WRITE(3'b001), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .QUANTUM(8), .TAG_DEPTH(32)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .init_calib_complete(calib),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
    .grant_out(grant_out), .tag_err_out(tag_err_out), .mig(mig_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int acc_q[$];     // requester id of every outstanding read, oldest first
  int pend_q[$];    // cycle at which the MIG returns each pending read
  int rd_log[$];    // requester id of every routed beat
  int cyc = 0;
  bit ret_en = 1'b0;
  int inj_req = 0;
  int inj_done = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Each requester's address carries its id in the top two bits.
  task automatic rand_inputs();
    for (int i = 0; i < 3; i++) begin
      req_addr[i]  = {2'(i), 25'($urandom())};
      req_wdata[i] = rnd128();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rand_inputs();
  endtask

  // Hold req_valid = v until requester idx has been accepted n times.
  task automatic issue(input logic [2:0] v, input int idx, input int n, output int got);
    got = 0;
    req_valid = v;
    for (int c = 0; c < 80 && got < n; c++) begin
      #2;
      if (req_ready[idx]) got++;
      tick();
    end
    req_valid = 3'b000;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200 && acc_q.size() != 0; c++) tick();
    check(tag, acc_q.size(), 0);
  endtask

  // MIG responder and scoreboard: checks every command and every routed beat.
  always @(posedge clk) begin
    bit beat;
    bit nb;
    int rid;
    int id;
    logic [127:0] bdata;
    beat = 1'b0;
    rid = -1;
    bdata = '0;
    if (rst_n) begin
      if (mig_bus.app_rd_data_valid) begin
        beat = 1'b1;
        bdata = mig_bus.app_rd_data;
        if (acc_q.size() > 0) rid = acc_q.pop_front();
      end
      if (mig_bus.app_en) begin
        id = int'(mig_bus.app_addr[ADDR_W-1 -: 2]);
        check("cmd_app_rdy", mig_bus.app_rdy, 1'b1);
        check("cmd_addr", mig_bus.app_addr, req_addr[id]);
        check("cmd_req_ready", req_ready, 3'(1) << id);
        check("cmd_grant", grant_out, 3'(1) << id);
        if (wr_map[id]) begin
          check("wr_cmd", mig_bus.app_cmd, CMD_WRITE);
          check("wr_wren", mig_bus.app_wdf_wren, 1'b1);
          check("wr_end", mig_bus.app_wdf_end, 1'b1);
          check("wr_data", mig_bus.app_wdf_data, req_wdata[id]);
        end else begin
          check("rd_cmd", mig_bus.app_cmd, CMD_READ);
          check("rd_wren", mig_bus.app_wdf_wren, 1'b0);
          acc_q.push_back(id);
          if (ret_en) pend_q.push_back(cyc + RD_LAT);
        end
      end else begin
        check("idle_req_ready", req_ready, 3'b000);
        check("idle_wren", mig_bus.app_wdf_wren, 1'b0);
      end
    end
    cyc++;
    #1;
    nb = 1'b0;
    if (rst_n) begin
      if (beat) begin
        if (rid >= 0) begin
          check("rd_route", rd_valid_out, 3'(1) << rid);
          check("rd_data", rd_data_out, bdata);
          rd_log.push_back(rid);
        end else begin
          check("stray_route", rd_valid_out, 3'b000);
          check("stray_err", tag_err_out, 1'b1);
        end
      end else begin
        check("rd_quiet", rd_valid_out, 3'b000);
      end
      if (pend_q.size() > 0 && pend_q[0] <= cyc) begin
        void'(pend_q.pop_front());
        nb = 1'b1;
      end else if (inj_done < inj_req) begin
        inj_done++;
        nb = 1'b1;
      end
    end
    mig_bus.app_rd_data_valid = nb;
    mig_bus.app_rd_data = rnd128();
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int got;
    int rd1;
    int wr_late;
    int acc;
    int exp_route[$];
    wr_map = 3'b001;
    rst_n = 1'b0;
    calib = 1'b0;
    req_valid = 3'b000;
    rand_inputs();
    mig_bus.app_rdy = 1'b0;
    mig_bus.app_wdf_rdy = 1'b0;
    mig_bus.app_rd_data_valid = 1'b0;
    mig_bus.app_rd_data = '0;

    // Reset state.
    tick();
    tick();
    #2;
    check("rst_grant", grant_out, 3'b000);
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_app_en", mig_bus.app_en, 1'b0);
    check("rst_wren", mig_bus.app_wdf_wren, 1'b0);
    check("rst_addr", mig_bus.app_addr, '0);
    check("rst_rd_valid", rd_valid_out, 3'b000);
    check("rst_tag_err", tag_err_out, 1'b0);
    tick();
    rst_n = 1'b1;

    // Calibration hold-off, then a single write.
    req_valid = 3'b001;
    mig_bus.app_rdy = 1'b1;
    mig_bus.app_wdf_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("cal_app_en", mig_bus.app_en, 1'b0);
      check("cal_grant", grant_out, 3'b000);
      tick();
    end
    calib = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      #2;
      if (mig_bus.app_en) begin
        got = 1;
        check("w1_grant", grant_out, 3'b001);
        check("w1_cmd", mig_bus.app_cmd, CMD_WRITE);
        check("w1_end", mig_bus.app_wdf_end, 1'b1);
      end
      tick();
    end
    check("w1_seen", got, 1);
    req_valid = 3'b000;
    #2;
    check("w1_single", mig_bus.app_en, 1'b0);
    tick();

    // Fairness: all valid, MIG always ready; writer was last, so order is 1,2,0,1,2,0.
    ret_en = 1'b1;
    req_valid = 3'b111;
    #2;
    check("fair_idle0", grant_out, 3'b000);
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        #2;
        check("fair_grant", grant_out, 3'(1) << ((1 + k) % 3));
        check("fair_app_en", mig_bus.app_en, 1'b1);
      end
      tick();
      #2;
      check("fair_gap_grant", grant_out, 3'b000);
      check("fair_gap_en", mig_bus.app_en, 1'b0);
    end
    req_valid = 3'b000;
    tick();
    drain("fair_drain");
    check("fair_tag_err", tag_err_out, 1'b0);

    // Read routing: 4 reads from req1, then 4 from req2, returned in order.
    rd_log.delete();
    issue(3'b010, 1, 4, got);
    check("route_req1_n", got, 4);
    issue(3'b100, 2, 4, got);
    check("route_req2_n", got, 4);
    drain("route_drain");
    exp_route = '{1, 1, 1, 1, 2, 2, 2, 2};
    check("route_cnt", rd_log.size(), 8);
    for (int i = 0; i < 8 && i < rd_log.size(); i++) check("route_seq", rd_log[i], exp_route[i]);

    // Stall: app_rdy toggles during a write grant; grant ends on exactly the 8th accept.
    tick();
    req_valid = 3'b001;
    #2;
    check("stall_idle", grant_out, 3'b000);
    acc = 0;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      tick();
      mig_bus.app_rdy = (c < 3) ? (c != 1) : 1'($urandom_range(0, 1));
      #2;
      check("stall_grant", grant_out, 3'b001);
      check("stall_ready", req_ready, mig_bus.app_rdy ? 3'b001 : 3'b000);
      check("stall_app_en", mig_bus.app_en, mig_bus.app_rdy);
      if (mig_bus.app_rdy) acc++;
    end
    tick();
    #2;
    check("stall_exit", grant_out, 3'b000);
    req_valid = 3'b000;
    mig_bus.app_rdy = 1'b1;
    tick();

    // Tag full: no returns; req1 gets exactly 32 reads, then only the writer is served.
    ret_en = 1'b0;
    req_valid = 3'b011;
    rd1 = 0;
    wr_late = 0;
    for (int c = 0; c < 150; c++) begin
      #2;
      if (req_ready[1]) rd1++;
      if (c >= 110 && req_ready[0]) wr_late++;
      tick();
    end
    check("full_rd_cnt", rd1, 32);
    check("full_writer_runs", wr_late > 0, 1'b1);
    // Five back-to-back returns: exactly five more reads fit, including push+pop cycles.
    req_valid = 3'b010;
    inj_req += 5;
    rd1 = 0;
    for (int c = 0; c < 60; c++) begin
      #2;
      if (req_ready[1]) rd1++;
      tick();
    end
    check("full_refill", rd1, 5);
    req_valid = 3'b000;
    inj_req += 32;
    drain("full_drain");
    check("full_tag_err", tag_err_out, 1'b0);

    // Reset with 5 reads outstanding and a read grant active.
    issue(3'b010, 1, 5, got);
    check("rst5_n", got, 5);
    req_valid = 3'b100;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      #2;
      if (mig_bus.app_en) got = 1;
      else tick();
    end
    check("rst5_busy", got, 1);
    rst_n = 1'b0;
    acc_q.delete();
    pend_q.delete();
    #1;
    check("arst_app_en", mig_bus.app_en, 1'b0);
    check("arst_req_ready", req_ready, 3'b000);
    check("arst_grant", grant_out, 3'b000);
    check("arst_wren", mig_bus.app_wdf_wren, 1'b0);
    check("arst_rd_valid", rd_valid_out, 3'b000);
    tick();
    req_valid = 3'b000;
    tick();
    check("arst_tag_err", tag_err_out, 1'b0);
    rst_n = 1'b1;
    rd_log.delete();
    tick();
    inj_req += 1;
    for (int c = 0; c < 4; c++) tick();
    #2;
    check("stray_sticky", tag_err_out, 1'b1);
    check("stray_no_route", rd_log.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
